pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Sequences the F->D->E->M pipeline latches (fetch_to_decode, decode_to_execute, execute_to_memory) by driving each latch's en/flush pair and the PC enable.
- Resolves load-use hazards, taken branches/jumps, instruction-fetch and data-memory wait states, and program halt.
- Sits beside the datapath as the hazard unit. It consumes decode-stage source registers and the decode_to_execute latched fields.

Parameters:
- MEM_TIMEOUT, 64: max consecutive data-memory wait cycles before a fatal timeout; must be >=1.
- CNT_W, 32: width of optional performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  decode-stage rs1 (reg_t)
- id_rs2  in  5  decode-stage rs2 (reg_t)
- id_use_rs1  in  1  decode instr reads rs1
- id_use_rs2  in  1  decode instr reads rs2
- ex_rd  in  5  decode_to_execute rd
- ex_dread  in  1  decode_to_execute dread (load in execute)
- ex_redirect  in  1  execute resolved taken branch, JAL or JALR
- mem_req  in  1  memory stage issuing a data access
- dmem_ready  in  1  data access completes this cycle
- imem_ready  in  1  instruction fetch completes this cycle
- mem_halt  in  1  halt instruction in memory stage
- pc_en  out  1  PC register update
- f2d_en, f2d_flush  out  1,1  fetch_to_decode control
- d2e_en, d2e_flush  out  1,1  decode_to_execute control
- e2m_en, e2m_flush  out  1,1  execute_to_memory control
- halted  out  1  core halted (sticky)
- mem_timeout  out  1  fatal data-memory timeout (sticky)

Behaviour:
- Latch semantics: flush=1 loads a bubble (all zeros) and overrides en; en=0 holds the latch.
- States: RUN, DSTALL, HALTED. Reset -> RUN. Wait counter = 0.
- Outputs during reset: all en=0, all flush=0, halted=0, mem_timeout=0.
- Outputs are combinational from state and inputs. State, wait counter, halted and mem_timeout are registered.
- In RUN and DSTALL, the first matching rule in this priority order sets the outputs:
  1. mem_halt: all en=0, flush=0; next state HALTED.
  2. mem_req && !dmem_ready: freeze, all en=0, flush=0; next state DSTALL; wait counter +1.
  3. ex_redirect: pc_en=1 (target loaded), f2d_flush=1, d2e_flush=1, e2m_en=1. This applies even when imem_ready=0.
  4. Load-use: ex_dread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). Outputs: pc_en=0, f2d_en=0, d2e_flush=1, e2m_en=1. This inserts exactly one bubble.
  5. !imem_ready: pc_en=0, f2d_flush=1, d2e_en=1, e2m_en=1.
  6. Otherwise: all en=1, all flush=0.
- Rules 3-6 return the state to RUN and clear the wait counter.
- DSTALL timeout: if the wait counter reaches MEM_TIMEOUT while still waiting, mem_timeout is set and the next state is HALTED.
- HALTED: all en=0, flush=0, halted=1. Leaves only on rst; all inputs are ignored.
- rst asserted mid-stall clears the counter and state immediately (asynchronous).
- The register x0 match is never a hazard.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three extra output ports exist, each CNT_W bits wide:
  - stall_cycles: counts cycles in which pc_en=0 outside HALTED.
  - flush_count: counts ex_redirect cycles.
  - loaduse_count: counts rule-4 cycles.
- Counters clear on rst, saturate at all-ones, and freeze in HALTED.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- The state enum hz_state_t {RUN, DSTALL, HALTED} belongs in common_types_pkg.
- reg_t and word_t are already in common_types_pkg.
- The load-use comparator is natural as a sub-module: hazard_detect, which is combinational and outputs a load_use flag. FSM and counters stay in the top level.

Test Plan:
- Load-use: ex_dread=1, ex_rd=5, id_use_rs2=1, id_rs2=5 for one cycle -> pc_en=0, f2d_en=0, d2e_flush=1, e2m_en=1 for exactly that cycle. Same stimulus with ex_rd=0 -> all en=1.
- Redirect with imem miss: ex_redirect=1, imem_ready=0 -> pc_en=1, f2d_flush=1, d2e_flush=1. Next cycle with no redirect -> pc_en=0, f2d_flush=1.
- Data wait: mem_req=1, dmem_ready=0 for 3 cycles, then ready -> 3 cycles with all en=0 (state DSTALL), then all en=1 and state RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 and halted=1 after 4 wait cycles, sticky. rst -> both clear.
- Halt priority: mem_halt=1 together with ex_redirect=1 -> all en=0 that cycle, halted=1 next cycle, later stimuli have no effect.
- HAZARD_PERF_EN: run 2 load-use stalls and 1 redirect -> loaduse_count=2, flush_count=1, stall_cycles=2.

Source files
------------

// File: rtl/common_types_pkg.sv
// common_types_pkg: shared core types (register index, data word, hazard FSM state)
package common_types_pkg;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {RUN, DSTALL, HALTED} hz_state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detector between decode sources and the load in execute
module hazard_detect
    import common_types_pkg::*;
(
    input  reg_t id_rs1,
    input  reg_t id_rs2,
    input  logic id_use_rs1,
    input  logic id_use_rs2,
    input  reg_t ex_rd,
    input  logic ex_dread,
    output logic load_use
);
    // x0 is hardwired to zero, so a write to it never creates a dependency
    assign load_use = ex_dread && (ex_rd != '0) &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: F->D->E->M latch sequencing for stalls, flushes, memory waits and halt
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import common_types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
    , parameter int CNT_W = 32
`endif
)(
    input  logic clk,
    input  logic rst,
    input  reg_t id_rs1,
    input  reg_t id_rs2,
    input  logic id_use_rs1,
    input  logic id_use_rs2,
    input  reg_t ex_rd,
    input  logic ex_dread,
    input  logic ex_redirect,
    input  logic mem_req,
    input  logic dmem_ready,
    input  logic imem_ready,
    input  logic mem_halt,
    output logic pc_en,
    output logic f2d_en,
    output logic f2d_flush,
    output logic d2e_en,
    output logic d2e_flush,
    output logic e2m_en,
    output logic e2m_flush,
    output logic halted,
    output logic mem_timeout
`ifdef HAZARD_PERF_EN
    , output logic [CNT_W-1:0] stall_cycles
    , output logic [CNT_W-1:0] flush_count
    , output logic [CNT_W-1:0] loaduse_count
`endif
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            halted_q, halted_d;
    logic            timeout_q, timeout_d;
    logic            load_use, active, dwait;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_dread   (ex_dread),
        .load_use   (load_use)
    );

    assign active      = !rst && state_q != HALTED;
    assign dwait       = mem_req && !dmem_ready;
    assign halted      = halted_q;
    assign mem_timeout = timeout_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        halted_d  = halted_q;
        timeout_d = timeout_q;
        pc_en     = 1'b0;
        f2d_en    = 1'b0;
        f2d_flush = 1'b0;
        d2e_en    = 1'b0;
        d2e_flush = 1'b0;
        e2m_en    = 1'b0;
        e2m_flush = 1'b0;
        if (active) begin
            if (mem_halt) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end else if (dwait) begin
                wait_d = wait_q + WW'(1);
                if (wait_d >= WW'(MEM_TIMEOUT)) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = DSTALL;
                end
            end else begin
                state_d = RUN;
                wait_d  = '0;
                e2m_en  = 1'b1;
                if (ex_redirect) begin
                    pc_en     = 1'b1;
                    f2d_flush = 1'b1;
                    d2e_flush = 1'b1;
                end else if (load_use) begin
                    d2e_flush = 1'b1;
                end else if (!imem_ready) begin
                    f2d_flush = 1'b1;
                    d2e_en    = 1'b1;
                end else begin
                    pc_en  = 1'b1;
                    f2d_en = 1'b1;
                    d2e_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q, flush_q, lu_q;
    logic             redir_hit, lu_hit;

    assign redir_hit     = active && !mem_halt && !dwait && ex_redirect;
    assign lu_hit        = active && !mem_halt && !dwait && !ex_redirect && load_use;
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;
    assign loaduse_count = lu_q;

    // counters saturate at all-ones; active already excludes HALTED so they freeze there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
            lu_q    <= '0;
        end else begin
            if (active && !pc_en && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
            if (redir_hit && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
            if (lu_hit && lu_q != '1) lu_q <= lu_q + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_pipeline_hazard_ctrl;
    import common_types_pkg::*;

    // vector order: pc_en f2d_en f2d_flush d2e_en d2e_flush e2m_en e2m_flush halted mem_timeout
    localparam logic [8:0] V_RUN = 9'b110101000;
    localparam logic [8:0] V_RED = 9'b101011000;
    localparam logic [8:0] V_LU  = 9'b000011000;
    localparam logic [8:0] V_IMS = 9'b001101000;
    localparam logic [8:0] V_FRZ = 9'b000000000;
    localparam logic [8:0] V_HLT = 9'b000000010;
    localparam logic [8:0] V_TOH = 9'b000000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    reg_t id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_dread, ex_redirect, mem_req, dmem_ready, imem_ready, mem_halt;
    logic pc_en, f2d_en, f2d_flush, d2e_en, d2e_flush, e2m_en, e2m_flush, halted, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count, loaduse_count;
`endif

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_dread    (ex_dread),
        .ex_redirect (ex_redirect),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .imem_ready  (imem_ready),
        .mem_halt    (mem_halt),
        .pc_en       (pc_en),
        .f2d_en      (f2d_en),
        .f2d_flush   (f2d_flush),
        .d2e_en      (d2e_en),
        .d2e_flush   (d2e_flush),
        .e2m_en      (e2m_en),
        .e2m_flush   (e2m_flush),
        .halted      (halted),
        .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_EN
        , .stall_cycles  (stall_cycles)
        , .flush_count   (flush_count)
        , .loaduse_count (loaduse_count)
`endif
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [8:0] e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {pc_en, f2d_en, f2d_flush, d2e_en, d2e_flush, e2m_en, e2m_flush, halted, mem_timeout};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %b expected %b", n, a, e);
            end
        end
    end

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_dread = 0; ex_redirect = 0;
        mem_req = 0; dmem_ready = 0; imem_ready = 1; mem_halt = 0;
    endtask

    task automatic cyc(input logic [8:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input reg_t rd);
        ex_dread = 1; ex_rd = rd; id_use_rs2 = 1; id_rs2 = 5;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        cyc(V_FRZ, "reset");
        rst = 0;
        cyc(V_RUN, "run");
        set_lu(5);            cyc(V_LU,  "loaduse_rs2");
        idle();               cyc(V_RUN, "loaduse_one_bubble");
        set_lu(0);            cyc(V_RUN, "loaduse_x0");
        idle(); ex_dread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
                              cyc(V_LU,  "loaduse_rs1");
        id_use_rs1 = 0;       cyc(V_RUN, "loaduse_unused_src");
        idle(); ex_redirect = 1; imem_ready = 0;
                              cyc(V_RED, "redirect_imiss");
        ex_redirect = 0;      cyc(V_IMS, "imiss_after_redirect");
        idle(); set_lu(5); ex_redirect = 1;
                              cyc(V_RED, "redirect_over_loaduse");
        idle(); mem_req = 1;
        for (int i = 0; i < 3; i++) cyc(V_FRZ, "dwait");
        dmem_ready = 1;       cyc(V_RUN, "dwait_done");
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) cyc(V_FRZ, "dwait_again");
        dmem_ready = 1;       cyc(V_RUN, "dwait_cnt_cleared");
        dmem_ready = 0;
        for (int i = 0; i < 2; i++) cyc(V_FRZ, "dwait_pre_rst");
        rst = 1;              cyc(V_FRZ, "rst_mid_stall");
        rst = 0;
        for (int i = 0; i < 3; i++) cyc(V_FRZ, "dwait_post_rst");
        dmem_ready = 1;       cyc(V_RUN, "dwait_post_rst_done");
        dmem_ready = 0;
        for (int i = 0; i < 4; i++) cyc(V_FRZ, "timeout_wait");
        cyc(V_TOH, "timeout_set");
        idle();               cyc(V_TOH, "timeout_sticky");
        ex_redirect = 1;      cyc(V_TOH, "timeout_ignores_inputs");
        idle(); rst = 1;      cyc(V_FRZ, "timeout_rst_clear");
        rst = 0;              cyc(V_RUN, "run_after_timeout");
        mem_halt = 1; ex_redirect = 1;
                              cyc(V_FRZ, "halt_priority");
        idle();               cyc(V_HLT, "halted");
        ex_redirect = 1;      cyc(V_HLT, "halted_ignores_redirect");
        idle(); mem_req = 1;  cyc(V_HLT, "halted_ignores_dwait");
        idle(); rst = 1;      cyc(V_FRZ, "halt_rst_clear");
        rst = 0;              cyc(V_RUN, "perf_run");
        set_lu(5);            cyc(V_LU,  "perf_lu1");
        idle();               cyc(V_RUN, "perf_gap");
        set_lu(5);            cyc(V_LU,  "perf_lu2");
        idle(); ex_redirect = 1;
                              cyc(V_RED, "perf_redirect");
        idle();               cyc(V_RUN, "perf_end");
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
`ifdef HAZARD_PERF_EN
        total += 3;
        if (loaduse_count !== 32'd2) begin bad++; $display("FAIL loaduse_count: got %0d expected 2", loaduse_count); end
        if (flush_count !== 32'd1) begin bad++; $display("FAIL flush_count: got %0d expected 1", flush_count); end
        if (stall_cycles !== 32'd2) begin bad++; $display("FAIL stall_cycles: got %0d expected 2", stall_cycles); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
